fp_mul_sched: RTL
=================

Name: fp_mul_sched

Overview:
Shares one pipelined floating-point multiplier among N_REQ requesters.
- Arbitrates requests round-robin and issues at most one operation per cycle into the multiplier's start/operand inputs.
- Tracks the requester ID of every in-flight operation in a tag pipeline aligned to the multiplier latency.
- Routes each result back to its originator as a single-cycle response pulse.
- Sits between the compute-engine request ports and the shared multiplier instance.

Parameters:
DATA_W, 32, floating-point word width
N_REQ, 4, number of requesters (2..16)
ID_W, 2, requester ID width, equals clog2(N_REQ)
MUL_LAT, 4, cycles from mul_start to mul_done of the attached multiplier

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  issue enable; 0 blocks new grants, in-flight ops still drain
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant, one-hot or zero
req_op_a  in  N_REQ*DATA_W  operand A, requester i in bits [i*DATA_W +: DATA_W]
req_op_b  in  N_REQ*DATA_W  operand B, same packing
mul_start  out  1  issue strobe to multiplier
mul_op_a  out  DATA_W  operand A to multiplier
mul_op_b  out  DATA_W  operand B to multiplier
mul_done  in  1  multiplier result-valid strobe
mul_res  in  DATA_W  multiplier result
resp_valid  out  N_REQ  one-hot result pulse to the originating requester
resp_data  out  DATA_W  result, shared across requesters
resp_id  out  ID_W  originating requester ID
busy  out  1  any operation in flight or awaiting response
seq_err  out  1  sticky tag/done mismatch flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - req_ready, mul_start, resp_valid, busy, seq_err = 0.
  - mul_op_a, mul_op_b, resp_data, resp_id = 0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - All tag pipeline entries invalid.
- Arbitration (combinational):
  - When en=1, req_ready[i]=1 for the first i with req_valid[i]=1, searching from ptr+1 upward and wrapping modulo N_REQ.
  - When en=0, or no requester is valid, req_ready=0.
  - Handshake = req_valid[i] & req_ready[i] in the same cycle.
  - req_ready never asserts without req_valid.
- Pointer update: on a handshake, ptr <= granted index. With no handshake, ptr holds.
- Issue stage (registered): in the cycle after a handshake:
  - mul_start=1.
  - mul_op_a/mul_op_b = granted requester's operands, captured at handshake.
  - Issue tag {valid=1, id=grant}.
  - Otherwise mul_start=0, operands hold their last values.
- Tag pipeline:
  - MUL_LAT-stage shift register of {valid, id}, loaded from the issue tag every cycle.
  - Its output is aligned with mul_done.
  - Capacity is exactly MUL_LAT+1 in-flight ops. No stall is ever needed, since the multiplier accepts one op per cycle.
- Response (registered):
  - When mul_done=1 and the tag output is valid: resp_valid[id]=1 for one cycle, resp_data=mul_res, resp_id=id.
  - Otherwise resp_valid=0; resp_data and resp_id hold.
  - Responses have no backpressure; requesters must accept.
- Latency: handshake at cycle T -> mul_start at T+1 -> mul_done at T+1+MUL_LAT -> resp_valid at T+2+MUL_LAT (T+6 at default).
- Ordering: responses return in issue order. Back-to-back issues give back-to-back responses.
- seq_err: set when mul_done != tag-output valid in any cycle. Stays 1 until rst. The mismatched result is dropped, with no resp_valid.
- busy = OR of issue-stage valid, all tag entries, and the response register valid.
- en deasserted mid-stream: no new grants; already accepted ops complete and respond normally.
- Simultaneous requests from all requesters: one grant per cycle. A fully loaded N_REQ set is served in N_REQ consecutive cycles. Each requester is granted at most once per N_REQ cycles while all others remain valid.
- Reset mid-operation: all in-flight tags are cleared and their results discarded. mul_done strobes arriving after reset with no valid tag are ignored and do not set seq_err in the first MUL_LAT+1 cycles after rst deasserts. seq_err checking is enabled only after that window.

Test Plan:
- Single op: req 0 valid, op_a=0x40000000, op_b=0x40400000 at T -> mul_start at T+1; resp_valid=0001, resp_data=0x40C00000, resp_id=0 at T+6.
- All four requesters valid continuously, operand pairs distinct -> grants in order 0,1,2,3,0 on consecutive cycles. Responses on consecutive cycles starting T+6, each routed to the correct ID. For example, req 2 with 0x3FC00000*0x3FC00000 returns 0x40100000.
- ptr=1 after a grant to requester 1; requesters 0 and 3 valid -> requester 3 granted next, then 0.
- en=0 with ops in flight and all req_valid high -> req_ready=0; the in-flight responses still arrive on schedule; no new mul_start.
- Model injects a spurious mul_done with no tag -> seq_err=1 next cycle, no resp_valid, sticky until rst.
- rst asserted for one cycle while 3 ops are in flight -> no resp_valid for those ops; busy=0 after reset; a new request is served with T+6 latency and seq_err remains 0.

Source files
------------

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one pipelined FP multiplier among N_REQ requesters.
// Tracks in-flight requester IDs in a tag pipeline and routes each result back as a one-cycle pulse.
//
// Handshake: a request transfers when req_valid[i] & req_ready[i] are high in the same cycle.
// req_ready is one-hot or zero and never asserts without req_valid.
// Responses have no backpressure.
module fp_mul_sched #(
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_op_a,
  input  logic [N_REQ*DATA_W-1:0] req_op_b,
  output logic                    mul_start,
  output logic [DATA_W-1:0]       mul_op_a,
  output logic [DATA_W-1:0]       mul_op_b,
  input  logic                    mul_done,
  input  logic [DATA_W-1:0]       mul_res,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy,
  output logic                    seq_err
);

  localparam int GW = $clog2(MUL_LAT + 2);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand_id;
  logic              gnt_found;
  int                cand;
  logic [DATA_W-1:0] sel_a, sel_b;

  logic              start_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [ID_W-1:0]   iss_id_q;

  logic [MUL_LAT-1:0] tag_v_q;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];

  logic [N_REQ-1:0]  resp_v_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ID_W-1:0]   resp_id_q;
  logic              seq_err_q;
  logic [GW-1:0]     guard_q;

  logic              tag_out_v;
  logic [ID_W-1:0]   tag_out_id;
  logic              resp_fire;

  // Search starts one past the last winner and wraps, so the winner drops to lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_id   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand    = (int'(ptr_q) + k) % N_REQ;
      cand_id = ID_W'(cand);
      if (!gnt_found && req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_id;
      end
    end
    if (!en || rst) gnt_found = 1'b0;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        sel_a = req_op_a[i*DATA_W +: DATA_W];
        sel_b = req_op_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) ptr_d = gnt_idx;
  end

  assign tag_out_v  = tag_v_q[MUL_LAT-1];
  assign tag_out_id = tag_id_q[MUL_LAT-1];
  assign resp_fire  = mul_done & tag_out_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= ID_W'(N_REQ - 1);
      start_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      iss_id_q    <= '0;
      tag_v_q     <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
      resp_v_q    <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      seq_err_q   <= 1'b0;
      guard_q     <= GW'(MUL_LAT + 1);
    end else begin
      ptr_q   <= ptr_d;
      start_q <= gnt_found;
      if (gnt_found) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        iss_id_q <= gnt_idx;
      end
      tag_v_q[0]  <= start_q;
      tag_id_q[0] <= iss_id_q;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      resp_v_q <= resp_fire ? (N_REQ'(1) << tag_out_id) : '0;
      if (resp_fire) begin
        resp_data_q <= mul_res;
        resp_id_q   <= tag_out_id;
      end
      // Results of ops killed by reset may still strobe mul_done; ignore them for one pipeline depth.
      if (guard_q != '0) guard_q <= guard_q - GW'(1);
      else if (mul_done != tag_out_v) seq_err_q <= 1'b1;
    end
  end

  assign req_ready  = gnt_found ? (N_REQ'(1) << gnt_idx) : '0;
  assign mul_start  = start_q;
  assign mul_op_a   = op_a_q;
  assign mul_op_b   = op_b_q;
  assign resp_valid = resp_v_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign seq_err    = seq_err_q;
  assign busy       = start_q | (|tag_v_q) | (|resp_v_q);

endmodule
